// File: rtl/alu_seq_if.sv
// Handshake/operand/result bundle for alu_seq. The master drives the request side
// and the slave (the ALU) drives the result side.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       switches;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, switches, OpA, OpB,
        input  result, carry, zero, busy, done
    );

    modport slave (
        input  start, switches, OpA, OpB,
        output result, carry, zero, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/add/sub ops and, when ALU_SEQ_MUL_EN is
// defined, a WIDTH-cycle shift-add multiplier on opcode 101.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    state_t           state_reg, state_next;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg, zero_reg, done_reg;

    logic [WIDTH-1:0] nand_vec;
    logic [WIDTH:0]   sum_full, diff_full;
    logic [WIDTH-1:0] exec_res;
    logic             exec_carry;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_ON = 1'b1;
    localparam int CW = $clog2(WIDTH + 1);
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] prod_reg, mcand_reg;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_nand
            assign nand_vec[gi] = ~(a_reg[gi] & b_reg[gi]);
        end
    endgenerate

    // Bit WIDTH of the widened difference is the unsigned borrow (A < B).
    assign sum_full  = {1'b0, a_reg} + {1'b0, b_reg};
    assign diff_full = {1'b0, a_reg} - {1'b0, b_reg};

    always_comb begin
        exec_res   = '0;
        exec_carry = 1'b0;
        case (op_reg)
            3'b010: exec_res = a_reg | b_reg;
            3'b011: exec_res = a_reg & b_reg;
            3'b100: exec_res = nand_vec;
            3'b110: begin
                exec_res   = sum_full[WIDTH-1:0];
                exec_carry = sum_full[WIDTH];
            end
            3'b111: begin
                exec_res   = diff_full[WIDTH-1:0];
                exec_carry = diff_full[WIDTH];
            end
            default: begin
                exec_res   = '0;
                exec_carry = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (MUL_ON && bus.switches == 3'b101) state_next = MUL;
                    else                                  state_next = EXEC;
                end
            end
            EXEC: state_next = IDLE;
            MUL: begin
`ifdef ALU_SEQ_MUL_EN
                if (cnt_reg == CW'(WIDTH)) state_next = IDLE;
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            zero_reg   <= 1'b1;
            done_reg   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            cnt_reg    <= '0;
            prod_reg   <= '0;
            mcand_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        op_reg <= bus.switches;
                        a_reg  <= bus.OpA;
                        b_reg  <= bus.OpB;
`ifdef ALU_SEQ_MUL_EN
                        cnt_reg   <= '0;
                        prod_reg  <= '0;
                        mcand_reg <= {{WIDTH{1'b0}}, bus.OpA};
`endif
                    end
                end
                EXEC: begin
                    result_reg <= exec_res;
                    carry_reg  <= exec_carry;
                    zero_reg   <= (exec_res == '0);
                    done_reg   <= 1'b1;
                end
`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    // WIDTH shift-add steps (b_reg consumed LSB first), then one write-back cycle.
                    if (cnt_reg == CW'(WIDTH)) begin
                        result_reg <= prod_reg[WIDTH-1:0];
                        carry_reg  <= |prod_reg[2*WIDTH-1:WIDTH];
                        zero_reg   <= (prod_reg[WIDTH-1:0] == '0);
                        done_reg   <= 1'b1;
                    end else begin
                        if (b_reg[0]) prod_reg <= prod_reg + mcand_reg;
                        mcand_reg <= mcand_reg << 1;
                        b_reg     <= b_reg >> 1;
                        cnt_reg   <= cnt_reg + CW'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.result = result_reg;
    assign bus.carry  = carry_reg;
    assign bus.zero   = zero_reg;
    assign bus.done   = done_reg;
    assign bus.busy   = (state_reg != IDLE);
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, multi-cycle corner
// sequences and randomized ops checked against an arithmetic reference model.
module tb_alu_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8))  if8();
    alu_seq_if #(.WIDTH(16)) if16();

    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));
    alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(if16));

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input bit w16, input logic s, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (w16) begin
            if16.start = s; if16.switches = op; if16.OpA = a[15:0]; if16.OpB = b[15:0];
        end else begin
            if8.start = s; if8.switches = op; if8.OpA = a[7:0]; if8.OpB = b[7:0];
        end
    endtask

    task automatic sample(input bit w16, output logic [31:0] r, output logic c,
                          output logic z, output logic bz, output logic d);
        if (w16) begin
            r = {16'd0, if16.result}; c = if16.carry; z = if16.zero; bz = if16.busy; d = if16.done;
        end else begin
            r = {24'd0, if8.result}; c = if8.carry; z = if8.zero; bz = if8.busy; d = if8.done;
        end
    endtask

    // Reference: plain unsigned arithmetic on the operation's definition.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
        longint unsigned mask, aa, bb, p;
        logic [31:0] r;
        logic c;
        mask = (64'd1 << w) - 64'd1;
        aa = {32'd0, a} & mask;
        bb = {32'd0, b} & mask;
        r = '0;
        c = 1'b0;
        case (op)
            3'b010: r = 32'(aa | bb);
            3'b011: r = 32'(aa & bb);
            3'b100: r = 32'(~(aa & bb) & mask);
            3'b110: begin p = aa + bb; r = 32'(p & mask); c = (p >> w) != 0; end
            3'b111: begin r = 32'((aa + (64'd1 << w) - bb) & mask); c = aa < bb; end
            3'b101: if (MUL_ON) begin p = aa * bb; r = 32'(p & mask); c = (p >> w) != 0; end
            default: ;
        endcase
        return {c, r};
    endfunction

    function automatic int lat_of(input logic [2:0] op, input int w);
        return (MUL_ON && op == 3'b101) ? w + 1 : 1;
    endfunction

    // Issue one op, scramble inputs once accepted, then check timing and outputs.
    task automatic run_op(input bit w16, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input logic exp_c,
                          input int exp_lat, input string tag);
        logic [31:0] r;
        logic c, z, bz, d;
        int lat;
        drive(w16, 1'b1, op, a, b);
        @(negedge clk);
        sample(w16, r, c, z, bz, d);
        chk({tag, " busy_after_accept"}, bz, 1);
        drive(w16, 1'b0, 3'($urandom), $urandom, $urandom);
        lat = 0;
        while (!d && lat < 200) begin
            @(negedge clk);
            lat++;
            sample(w16, r, c, z, bz, d);
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " result"}, r, exp_r);
        chk({tag, " carry"}, c, exp_c);
        chk({tag, " zero"}, z, exp_r == 0);
        chk({tag, " busy_at_done"}, bz, 0);
        $display("txn %s w=%0d op=%b a=%0h b=%0h -> result=%0h carry=%0b zero=%0b lat=%0d",
                 tag, w16 ? 16 : 8, op, a, b, r, c, z, lat);
        @(negedge clk);
        sample(w16, r, c, z, bz, d);
        chk({tag, " done_one_cycle"}, d, 0);
    endtask

    task automatic check_reset_state(input bit w16, input string tag);
        logic [31:0] r;
        logic c, z, bz, d;
        sample(w16, r, c, z, bz, d);
        chk({tag, " result"}, r, 0);
        chk({tag, " carry"}, c, 0);
        chk({tag, " zero"}, z, 1);
        chk({tag, " busy"}, bz, 0);
        chk({tag, " done"}, d, 0);
    endtask

    initial begin
        logic [31:0] r, ra, rb;
        logic [32:0] e;
        logic [2:0]  op, op_l;
        logic c, z, bz, d;
        int lat, ndone;

        vecs[0]  = '{3'b010, 8'hF0, 8'h3C, 8'hFC, 1'b0};
        vecs[1]  = '{3'b011, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[2]  = '{3'b100, 8'hF0, 8'h3C, 8'hCF, 1'b0};
        vecs[3]  = '{3'b110, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[4]  = '{3'b111, 8'h05, 8'h07, 8'hFE, 1'b1};
        vecs[5]  = '{3'b000, 8'hF0, 8'h3C, 8'h00, 1'b0};
        vecs[6]  = '{3'b001, 8'hAB, 8'hCD, 8'h00, 1'b0};
`ifdef ALU_SEQ_MUL_EN
        vecs[7]  = '{3'b101, 8'h0F, 8'h11, 8'hFF, 1'b0};
        vecs[8]  = '{3'b101, 8'h10, 8'h10, 8'h00, 1'b1};
`else
        vecs[7]  = '{3'b101, 8'h0F, 8'h11, 8'h00, 1'b0};
        vecs[8]  = '{3'b101, 8'h10, 8'h10, 8'h00, 1'b0};
`endif
        vecs[9]  = '{3'b111, 8'h07, 8'h05, 8'h02, 1'b0};
        vecs[10] = '{3'b110, 8'h7F, 8'h01, 8'h80, 1'b0};

        reset = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 0, 0);
        drive(1'b1, 1'b0, 3'b000, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_state(1'b0, "reset8");
        check_reset_state(1'b1, "reset16");

        foreach (vecs[i])
            run_op(1'b0, vecs[i].op, {24'd0, vecs[i].a}, {24'd0, vecs[i].b},
                   {24'd0, vecs[i].r}, vecs[i].c, lat_of(vecs[i].op, 8), $sformatf("vec%0d", i));

        run_op(1'b1, 3'b110, 32'hFFFF, 32'h0001, 32'h0, 1'b1, 1, "w16_add_wrap");
        run_op(1'b1, 3'b111, 32'h0001, 32'h0002, 32'hFFFF, 1'b1, 1, "w16_sub_borrow");

        // Start re-pulsed with new operands while busy must be ignored.
        op_l = MUL_ON ? 3'b101 : 3'b110;
        e = model(op_l, 32'h0F, 32'h11, 8);
        drive(1'b0, 1'b1, op_l, 32'h0F, 32'h11);
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b111, 32'hFF, 32'h01);
        @(negedge clk);
        lat = 1;
        drive(1'b0, 1'b0, 3'b111, 32'hFF, 32'h01);
        sample(1'b0, r, c, z, bz, d);
        while (!d && lat < 200) begin
            @(negedge clk);
            lat++;
            sample(1'b0, r, c, z, bz, d);
        end
        chk("repulse latency", lat, lat_of(op_l, 8));
        chk("repulse result", r, e[31:0]);
        chk("repulse carry", c, e[32]);
        $display("txn repulse op=%b result=%0h carry=%0b lat=%0d", op_l, r, c, lat);
        @(negedge clk);
        sample(1'b0, r, c, z, bz, d);
        chk("repulse not_accepted", bz, 0);

        // Reset mid-operation aborts with no done pulse.
        drive(1'b0, 1'b1, op_l, 32'h0F, 32'h11);
        @(negedge clk);
        drive(1'b0, 1'b0, op_l, 32'h0F, 32'h11);
        repeat (MUL_ON ? 4 : 0) @(negedge clk);
        sample(1'b0, r, c, z, bz, d);
        chk("abort busy_before", bz, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state(1'b0, "abort");
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            sample(1'b0, r, c, z, bz, d);
            if (d) ndone++;
        end
        chk("abort no_done", ndone, 0);
        $display("txn abort op=%b result=%0h busy=%0b", op_l, r, bz);

        // Start coincident with reset is dropped.
        reset = 1'b1;
        drive(1'b0, 1'b1, 3'b110, 32'h12, 32'h34);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 3'b110, 32'h12, 32'h34);
        sample(1'b0, r, c, z, bz, d);
        chk("start_with_reset busy", bz, 0);
        @(negedge clk);
        sample(1'b0, r, c, z, bz, d);
        chk("start_with_reset result", r, 0);
        $display("txn start_with_reset busy=%0b result=%0h", bz, r);

        // Start held high: one ADD every two cycles.
        drive(1'b0, 1'b1, 3'b110, 32'h03, 32'h04);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sample(1'b0, r, c, z, bz, d);
            if (d) begin
                ndone++;
                chk("b2b result", r, 32'h07);
            end
        end
        drive(1'b0, 1'b0, 3'b110, 32'h03, 32'h04);
        chk("b2b done_count", ndone, 10);
        $display("txn back_to_back dones=%0d", ndone);
        @(negedge clk);
        sample(1'b0, r, c, z, bz, d);
        chk("b2b idle_after", bz, 0);

        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom);
            ra = $urandom & 32'hFF;
            rb = $urandom & 32'hFF;
            e  = model(op, ra, rb, 8);
            run_op(1'b0, op, ra, rb, e[31:0], e[32], lat_of(op, 8), "rand8");
        end
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom);
            ra = $urandom & 32'hFFFF;
            rb = $urandom & 32'hFFFF;
            e  = model(op, ra, rb, 16);
            run_op(1'b1, op, ra, rb, e[31:0], e[32], lat_of(op, 16), "rand16");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 4..32).
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 switches  input  3  operation select, latched with the operands on an accepted start.
REQ-006 OpA  input  WIDTH  operand A.
REQ-007 OpB  input  WIDTH  operand B.
REQ-008 result  output  WIDTH  registered result; holds its value until the next completion.
REQ-009 carry  output  1  registered flag: ADD carry-out, SUB borrow, MUL overflow.
REQ-010 zero  output  1  registered flag; high when result equals 0.
REQ-011 busy  output  1  high while an accepted operation is in progress.
REQ-012 done  output  1  one-cycle pulse in the cycle in which result and flags update.

Function
REQ-013 The FSM SHALL have three states: IDLE, EXEC and MUL.
REQ-014 Start acceptance: start=1 in IDLE SHALL latch OpA, OpB and switches and assert busy on the next edge.
REQ-015 IDLE exit: IDLE SHALL go to MUL when the latched op is 101 and the multiply feature is compiled in; otherwise it SHALL go to EXEC.
REQ-016 Opcodes: 010 OR, 011 AND, 100 NAND (bitwise inverse of AND), 110 ADD (A+B), 111 SUB (A-B); 000, 001, and 101 without the macro SHALL yield 0.
REQ-017 EXEC duration: EXEC SHALL last exactly one cycle, then write result/carry/zero, pulse done and return to IDLE.
REQ-018 Single-cycle latency: start accepted at edge N SHALL give done=1 and valid result after edge N+1.
REQ-019 ADD/SUB width rules: both SHALL wrap modulo 2^WIDTH; carry = bit WIDTH of A+B; SUB carry = 1 when A<B (unsigned).
REQ-020 Logic-op carry: OR, AND, NAND and the zero-result opcodes SHALL drive carry=0.
REQ-021 MUL sequence: MUL SHALL run an unsigned shift-add over exactly WIDTH cycles, one multiplier bit per cycle (LSB first), using a 2*WIDTH-bit internal product.
REQ-022 MUL completion: at completion, result SHALL be the low WIDTH bits of the product and carry SHALL be 1 when the high WIDTH bits are nonzero; done pulses and the FSM returns to IDLE.
REQ-023 MUL latency: start accepted at edge N SHALL give done=1 after edge N+WIDTH+1.
REQ-024 start while busy: start asserted while busy=1 SHALL be ignored, and operands changing mid-operation SHALL have no effect.
REQ-025 Back-to-back: start held high through done SHALL be accepted in the first IDLE cycle after done, giving one operation per (latency+1) cycles.
REQ-026 Idle behaviour: busy=1 exactly in EXEC and MUL; done SHALL never be high in IDLE except the completion cycle.

Reset
REQ-027 Reset values: reset=1 at an edge SHALL force IDLE, result=0, carry=0, zero=1, busy=0, done=0 and clear the internal product and counter.
REQ-028 Reset priority: reset SHALL override start and abort any EXEC or MUL in progress with no done pulse; a start coincident with reset SHALL be dropped.

Configuration
REQ-029 Macro: ALU_SEQ_MUL_EN.
- Defined: opcode 101 is the multi-cycle multiplier (REQ-021..023).
- Undefined: no multiplier, product or counter logic is synthesised; 101 behaves as a single-cycle op yielding result=0, carry=0, zero=1.

Verification
REQ-030 Logic ops: WIDTH=8, OpA=8'hF0, OpB=8'h3C, ops 010/011/100 -> result 8'hFC/8'h30/8'hCF, carry=0, done one cycle after start.
REQ-031 Add/sub boundaries: ADD 8'hFF+8'h01 -> result 8'h00, carry=1, zero=1; SUB 8'h05-8'h07 -> result 8'hFE, carry=1.
REQ-032 Multiply: macro defined, MUL 8'h0F*8'h11 -> result 8'hFF, carry=0, done exactly 9 cycles after start; MUL 8'h10*8'h10 -> result 8'h00, carry=1.
REQ-033 Busy/abort: start re-pulsed with new operands during MUL -> ignored, original result delivered; reset asserted at MUL cycle 4 -> IDLE next edge, all outputs at reset values, no done.
REQ-034 Macro off: macro undefined, op 101 with any operands -> result 0, zero=1, done one cycle after start.
REQ-035 Width sweep: repeat REQ-031 with WIDTH=16 (16'hFFFF+16'h0001) -> result 0, carry=1.
